// File: rtl/spi_pkg.sv
// Shared SPI lab definitions: receiver FSM state encoding and default frame geometry.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/read_from_slave_if.sv
// SPI receive-side bus: frame request, serial lines and received-word outputs.
// Handshake: rx_valid is a single-cycle strobe with no ready; rx_data is valid
// whenever rx_valid is high and holds until the next completed frame. start is
// a level request and is only looked at while the receiver is idle.
interface read_from_slave_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              MISO;
  logic              SLK;
  logic              CS;
  logic              busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  // Receiver side (the SPI master that clocks the slave).
  modport master (
    input  start,
    input  MISO,
    output SLK,
    output CS,
    output busy,
    output rx_data,
    output rx_valid
  );

  // Environment side: requests frames, drives MISO, consumes the word.
  modport slave (
    output start,
    output MISO,
    input  SLK,
    input  CS,
    input  busy,
    input  rx_data,
    input  rx_valid
  );
endinterface

// File: rtl/read_from_slave_sync2.sv
// Two-flop synchronizer for the asynchronous MISO line, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // Two back-to-back flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/read_from_slave.sv
// SPI master receiver: on start, raises CS, emits DATA_W SLK pulses and shifts
// MISO in MSB first on each SLK fall, then strobes rx_valid with the word.
// Optional build macro SPI_MISO_SYNC_EN inserts a two-flop MISO synchronizer
// (requires CLK_DIV >= 3 so the synced bit is stable at the sample edge).
module read_from_slave
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  read_from_slave_if.master  bus,
  output state_t             dbg_state
);
  localparam int PH_W = $clog2(CLK_DIV + 1);
  localparam int BC_W = $clog2(DATA_W + 1);

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [BC_W-1:0]   bitcnt;
  logic [DATA_W-1:0] shreg;
  logic              miso_s;
  logic              phase_end;

`ifdef SPI_MISO_SYNC_EN
  // The synchronizer adds two cycles of delay, which must fit inside one SLK
  // high phase so the sampled bit belongs to the current pulse.
  if (CLK_DIV < 3) begin : g_clk_div_check
    $error("read_from_slave: CLK_DIV must be >= 3 with SPI_MISO_SYNC_EN");
  end

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.MISO),
    .q   (miso_s)
  );
`else
  assign miso_s = bus.MISO;
`endif

  assign phase_end = (phase == PH_W'(CLK_DIV - 1));
  assign dbg_state = state;

  // Frame FSM with phase/bit counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      bus.SLK      <= 1'b0;
      bus.CS       <= 1'b0;
      bus.busy     <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SETUP;
            phase    <= '0;
            bitcnt   <= '0;
            bus.CS   <= 1'b1;
            bus.busy <= 1'b1;
            bus.SLK  <= 1'b0;
          end
        end
        SETUP: begin
          if (phase_end) begin
            state   <= HIGH;
            phase   <= '0;
            bus.SLK <= 1'b1;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            // SLK falls here: this is the MISO sample point.
            state   <= LOW;
            phase   <= '0;
            bus.SLK <= 1'b0;
            shreg   <= {shreg[DATA_W-2:0], miso_s};
            bitcnt  <= bitcnt + BC_W'(1);
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        LOW: begin
          if (phase_end) begin
            phase <= '0;
            if (bitcnt < BC_W'(DATA_W)) begin
              state   <= HIGH;
              bus.SLK <= 1'b1;
            end else begin
              state        <= IDLE;
              bus.CS       <= 1'b0;
              bus.busy     <= 1'b0;
              bus.rx_data  <= shreg;
              bus.rx_valid <= 1'b1;
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_read_from_slave.sv
// Directed bench for read_from_slave: idle, single frames, ignored start,
// back-to-back frames and mid-frame reset, against a MISO slave model.
module tb_read_from_slave;
  import spi_pkg::*;

`ifdef SPI_MISO_SYNC_EN
  localparam int CLK_DIV = 3;
`else
  localparam int CLK_DIV = 4;
`endif
  localparam int DATA_W   = 8;
  localparam int FRAME_END = (2 * DATA_W + 1) * CLK_DIV;  // last cycle with CS high

  logic   clk;
  logic   rst;
  state_t dbg_state;

  read_from_slave_if #(.DATA_W(DATA_W)) bus ();

  read_from_slave #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks;
  int n_fail;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] last_word;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: presents the next bit MSB first on each SLK rise while CS high.
  initial begin : slave_model
    int   bitidx;
    logic slk_prev;
    bitidx   = 0;
    slk_prev = 1'b0;
    bus.MISO = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.CS) begin
        bitidx = 0;
      end else if (bus.SLK && !slk_prev && bitidx < DATA_W) begin
        bus.MISO = tx_word[DATA_W-1-bitidx];
        bitidx   = bitidx + 1;
      end
      slk_prev = bus.SLK;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Launches a frame from a negedge and checks every cycle up to rx_valid.
  // hold keeps start high; poke re-asserts start around cycle 30 mid-frame.
  task automatic run_frame(input logic [DATA_W-1:0] w, input bit hold, input bit poke);
    int   pulses;
    int   valids;
    logic prev_slk;
    logic exp_slk;
    tx_word   = w;
    bus.start = 1'b1;
    @(posedge clk);  // edge 0
    #1;
    if (!hold) bus.start = 1'b0;
    pulses   = 0;
    valids   = 0;
    prev_slk = 1'b0;
    for (int c = 1; c <= FRAME_END + 1; c++) begin
      @(negedge clk);
      if (poke && c == 30) bus.start = 1'b1;
      if (poke && c == 31) bus.start = 1'b0;
      exp_slk = (c <= FRAME_END) && ((((c - 1) / CLK_DIV) % 2) == 1);
      check("cs",       32'(bus.CS),       32'(c <= FRAME_END));
      check("busy",     32'(bus.busy),     32'(c <= FRAME_END));
      check("slk",      32'(bus.SLK),      32'(exp_slk));
      check("rx_valid", 32'(bus.rx_valid), 32'(c == FRAME_END + 1));
      if (c <= FRAME_END) check("rx_data_hold", 32'(bus.rx_data), 32'(last_word));
      else                check("rx_data",      32'(bus.rx_data), 32'(w));
      if (bus.SLK && !prev_slk) pulses++;
      if (bus.rx_valid) valids++;
      prev_slk = bus.SLK;
    end
    check("slk_pulses", 32'(pulses), 32'(DATA_W));
    check("valid_cnt",  32'(valids), 32'd1);
    last_word = w;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    tx_word   = '0;
    last_word = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle with start low
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_cs",    32'(bus.CS),       32'd0);
      check("idle_slk",   32'(bus.SLK),      32'd0);
      check("idle_busy",  32'(bus.busy),     32'd0);
      check("idle_valid", 32'(bus.rx_valid), 32'd0);
    end
    check("idle_rx_data", 32'(bus.rx_data), 32'h00);
    check("idle_state",   32'(dbg_state),   32'(IDLE));

    // Single frames
    run_frame(8'hA5, 1'b0, 1'b0);

    // Start during a frame is ignored
    run_frame(8'h3C, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_poke_cs",    32'(bus.CS),       32'd0);
      check("post_poke_valid", 32'(bus.rx_valid), 32'd0);
      check("post_poke_data",  32'(bus.rx_data),  32'h3C);
    end

    // Start held high: back-to-back frames, one IDLE cycle apart
    run_frame(8'hFF, 1'b1, 1'b0);
    run_frame(8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_end_cs", 32'(bus.CS), 32'd0);

    // Reset at cycle 40 of a frame
    tx_word   = 8'h77;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) @(negedge clk);
    check("pre_rst_cs", 32'(bus.CS), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_cs",      32'(bus.CS),       32'd0);
    check("rst_slk",     32'(bus.SLK),      32'd0);
    check("rst_busy",    32'(bus.busy),     32'd0);
    check("rst_valid",   32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data),  32'h00);
    check("rst_state",   32'(dbg_state),    32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("after_rst_valid", 32'(bus.rx_valid), 32'd0);
      check("after_rst_cs",    32'(bus.CS),       32'd0);
    end
    last_word = '0;
    run_frame(8'h5A, 1'b0, 1'b0);
    run_frame(8'hC3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
